block_gen: RTL

BLOCK_GEN -- requirements
Module: block_gen

---
 rtl/mure_pkg.sv | 40 ++++
 rtl/block_fifo.sv | 57 +++++
 rtl/block_gen.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/mure_pkg.sv
// Shared types and widths for the trace block generator and its output FIFO.
package mure_pkg;

    localparam int XLEN        = 32;
    localparam int ITYPE_LEN   = 4;
    localparam int CAUSE_LEN   = 5;
    localparam int PRIV_LEN    = 2;
    localparam int IRETIRE_LEN = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_e;

    typedef struct packed {
        logic                 valid;
        logic [XLEN-1:0]      pc;
        logic                 compressed;
        logic [ITYPE_LEN-1:0] itype;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } uop_entry_s;

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic                   ilastsize;
        logic [ITYPE_LEN-1:0]   itype;
        logic [CAUSE_LEN-1:0]   cause;
        logic [XLEN-1:0]        tval;
        logic [PRIV_LEN-1:0]    priv;
    } block_s;

    // Worst case per cycle: every port closes an overflowing block and its own block, plus a flush.
    function automatic int max_push(input int nret);
        return 2 * nret + 1;
    endfunction

endpackage

// File: rtl/block_fifo.sv
// Multi-push, single-pop FIFO of closed blocks; pointers wrap modulo DEPTH (any depth).
module block_fifo
    import mure_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int NPUSH = 5
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [$clog2(NPUSH+1)-1:0]   push_n_i,
    input  block_s                       push_data_i [NPUSH],
    input  logic                         pop_i,
    output block_s                       head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    block_s        mem [DEPTH];
    logic [AW-1:0] rd_q;
    logic [AW-1:0] wr_q;
    logic [CW-1:0] cnt_q;
    logic          pop_ok;

    // Offsets never exceed DEPTH, so one conditional subtraction is enough to wrap.
    function automatic logic [AW-1:0] wrap_add(input logic [AW-1:0] p, input int unsigned off);
        int unsigned s;
        s = 32'(p) + off;
        if (s >= 32'(DEPTH)) s = s - 32'(DEPTH);
        return AW'(s);
    endfunction

    assign pop_ok = pop_i && (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        for (int j = 0; j < NPUSH; j++) begin
            if (32'(j) < 32'(push_n_i)) mem[wrap_add(wr_q, 32'(j))] <= push_data_i[j];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wrap_add(wr_q, 32'(push_n_i));
            rd_q  <= pop_ok ? wrap_add(rd_q, 32'd1) : rd_q;
            cnt_q <= cnt_q + CW'(push_n_i) - CW'(pop_ok);
        end
    end

    assign head_o  = mem[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/block_gen.sv
// Groups retired uops into trace blocks and queues them for the encoder.
// Optional build macro: MURE_TVAL_EN stores the trap value with each block.
module block_gen
    import mure_pkg::*;
#(
    parameter int NRET        = 2,
    parameter int FIFO_DEPTH  = 8,
    parameter int IRETIRE_LEN = mure_pkg::IRETIRE_LEN
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  uop_entry_s             uop_entry_i [NRET],
    input  logic                   flush_i,
    output logic                   stall_o,
    output logic                   valid_o,
    input  logic                   ready_i,
    output logic [XLEN-1:0]        iaddr_o,
    output logic [IRETIRE_LEN-1:0] iretire_o,
    output logic                   ilastsize_o,
    output logic [ITYPE_LEN-1:0]   itype_o,
    output logic [CAUSE_LEN-1:0]   cause_o,
    output logic [XLEN-1:0]        tval_o,
    output logic [PRIV_LEN-1:0]    priv_o,
    output state_e                 state_o
);

    localparam int NPUSH = max_push(NRET);
    localparam int PW    = $clog2(NPUSH+1);
    localparam int BW    = mure_pkg::IRETIRE_LEN;
    localparam logic [IRETIRE_LEN:0] MAX_CNT = {1'b0, {IRETIRE_LEN{1'b1}}};

    state_e                 state_q, state_d;
    logic [IRETIRE_LEN-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]        iaddr_q, iaddr_d;
    logic                   last_q, last_d;
    logic [PW-1:0]          push_n;
    block_s                 push_data [NPUSH];
    logic [IRETIRE_LEN:0]   inc;
    logic [XLEN-1:0]        tv;
    logic                   stall;
    logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_cnt;
    block_s                 head;
    block_s                 head_v;

    function automatic block_s mk_block(input logic [XLEN-1:0] a, input logic [IRETIRE_LEN-1:0] n,
                                        input logic ls, input logic [ITYPE_LEN-1:0] it,
                                        input logic [CAUSE_LEN-1:0] c, input logic [XLEN-1:0] t,
                                        input logic [PRIV_LEN-1:0] p);
        block_s b;
        b.iaddr     = a;
        b.iretire   = BW'(n);
        b.ilastsize = ls;
        b.itype     = it;
        b.cause     = c;
        b.tval      = t;
        b.priv      = p;
        return b;
    endfunction

    assign stall = (32'(fifo_cnt) + 32'(NPUSH)) > 32'(FIFO_DEPTH);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        iaddr_d = iaddr_q;
        last_d  = last_q;
        push_n  = '0;
        inc     = '0;
        tv      = '0;
        for (int k = 0; k < NPUSH; k++) push_data[k] = '0;
        if (!stall) begin
            for (int i = 0; i < NRET; i++) begin
                if (uop_entry_i[i].valid) begin
                    // Compressed adds one half-word, full-size adds two.
                    inc = {{(IRETIRE_LEN-1){1'b0}}, !uop_entry_i[i].compressed, uop_entry_i[i].compressed};
                    if (state_d == COUNT && ({1'b0, cnt_d} + inc) > MAX_CNT) begin
                        push_data[push_n] = mk_block(iaddr_d, cnt_d, last_d, '0, '0, '0, '0);
                        push_n  = push_n + PW'(1);
                        state_d = IDLE;
                    end
                    if (state_d == IDLE) begin
                        iaddr_d = uop_entry_i[i].pc;
                        cnt_d   = '0;
                        state_d = COUNT;
                    end
                    cnt_d  = cnt_d + inc[IRETIRE_LEN-1:0];
                    last_d = !uop_entry_i[i].compressed;
                    if (uop_entry_i[i].itype != '0) begin
`ifdef MURE_TVAL_EN
                        tv = uop_entry_i[i].tval;
`else
                        tv = '0;
`endif
                        push_data[push_n] = mk_block(iaddr_d, cnt_d, last_d, uop_entry_i[i].itype,
                                                     uop_entry_i[i].cause, tv, uop_entry_i[i].priv);
                        push_n  = push_n + PW'(1);
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            if (flush_i && state_d == COUNT) begin
                push_data[push_n] = mk_block(iaddr_d, cnt_d, last_d, '0, '0, '0, '0);
                push_n  = push_n + PW'(1);
                state_d = IDLE;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            iaddr_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            iaddr_q <= iaddr_d;
            last_q  <= last_d;
        end
    end

    block_fifo #(
        .DEPTH (FIFO_DEPTH),
        .NPUSH (NPUSH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_n_i    (push_n),
        .push_data_i (push_data),
        .pop_i       (valid_o && ready_i),
        .head_o      (head),
        .count_o     (fifo_cnt)
    );

    // Storage behind an empty head is undefined, so outputs are forced to zero until a block exists.
    assign valid_o     = (fifo_cnt != '0);
    assign head_v      = valid_o ? head : '0;
    assign stall_o     = stall;
    assign iaddr_o     = head_v.iaddr;
    assign iretire_o   = head_v.iretire[IRETIRE_LEN-1:0];
    assign ilastsize_o = head_v.ilastsize;
    assign itype_o     = head_v.itype;
    assign cause_o     = head_v.cause;
    assign priv_o      = head_v.priv;
    assign state_o     = state_q;

`ifdef MURE_TVAL_EN
    assign tval_o = head_v.tval;
`else
    logic unused_tval;
    always_comb begin
        unused_tval = ^head_v.tval;
        for (int i = 0; i < NRET; i++) unused_tval = unused_tval ^ (^uop_entry_i[i].tval);
    end
    assign tval_o = '0;
`endif

endmodule
